// File: rtl/ctrl_cfg_writer_pkg.sv
// Shared definitions for the control-packet config writer: header layout,
// FSM encoding and small helpers used by the top and its FIFO.
package ctrl_cfg_writer_pkg;

  localparam int STAGE_LSB = 336;
  localparam int RES_LSB   = 344;
  localparam int IDX_LSB   = 352;
  localparam int CNT_LSB   = 360;

  localparam logic [15:0] CONTROL_PORT = 16'hf2f1;

  // Request record prefix: {stage_id, res_id, index}.
  localparam int REQ_HDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  function automatic int req_width(input int data_w);
    return REQ_HDR_W + data_w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ctrl_wr_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered full/empty.
// A push while full is ignored; pop_data reads as zero while empty.
module ctrl_wr_fifo #(
  parameter int WIDTH = 536,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Space is judged on the registered flag only, so a same-cycle pop never
  // makes room for a push.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale contents instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full     = full_q;
  assign valid    = ~empty_q;

endmodule

// File: rtl/ctrl_cfg_writer.sv
// Turns control packets into per-beat table-write requests: beat 0 carries the
// target header, each payload beat becomes one queued write.
module ctrl_cfg_writer
  import ctrl_cfg_writer_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic                              cfg_wr_valid,
  input  logic                              cfg_wr_ready,
  output logic [7:0]                        cfg_wr_stage_id,
  output logic [7:0]                        cfg_wr_res_id,
  output logic [7:0]                        cfg_wr_index,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    cfg_wr_data,
  output logic                              cfg_err,
  output logic [15:0]                       cfg_pkt_cnt,
  output logic [15:0]                       cfg_drop_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int REQ_W = req_width(DW);

  state_e      state_q, state_d;
  logic [7:0]  stage_q, stage_d;
  logic [7:0]  res_q, res_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  rem_q, rem_d;
  logic        err_q, err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic             fifo_push, fifo_full, fifo_valid;
  logic [REQ_W-1:0] fifo_wdata, fifo_rdata;
  logic [7:0]       hdr_cnt, rem_dec;
  logic             unused_inputs;

  assign unused_inputs = ^{c_s_axis_tkeep, c_s_axis_tuser};
  assign hdr_cnt       = c_s_axis_tdata[CNT_LSB +: 8];
  assign rem_dec       = rem_q - 8'd1;
  assign fifo_wdata    = {stage_q, res_q, idx_q, c_s_axis_tdata};

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    res_d      = res_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (c_s_axis_tvalid) begin
          stage_d = c_s_axis_tdata[STAGE_LSB +: 8];
          res_d   = c_s_axis_tdata[RES_LSB +: 8];
          idx_d   = c_s_axis_tdata[IDX_LSB +: 8];
          rem_d   = hdr_cnt;
          if (c_s_axis_tlast) begin
            // Header-only packet is good only when it announces no payload.
            if (hdr_cnt == 8'd0) pkt_cnt_d = sat_inc16(pkt_cnt_q);
            else                 err_d     = 1'b1;
          end else if (hdr_cnt == 8'd0) begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (c_s_axis_tvalid) begin
          if (fifo_full) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            err_d      = 1'b1;
            state_d    = c_s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else begin
            fifo_push = 1'b1;
            idx_d     = idx_q + 8'd1;
            rem_d     = rem_dec;
            if (c_s_axis_tlast) begin
              state_d = ST_IDLE;
              if (rem_dec == 8'd0) pkt_cnt_d = sat_inc16(pkt_cnt_q);
              else                 err_d     = 1'b1;
            end else if (rem_dec == 8'd0) begin
              err_d   = 1'b1;
              state_d = ST_DISCARD;
            end
          end
        end
      end

      ST_DISCARD: begin
        if (c_s_axis_tvalid && c_s_axis_tlast) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      res_q      <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      res_q      <= res_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ctrl_wr_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (aresetn),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (cfg_wr_ready),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .valid     (fifo_valid)
  );

  assign cfg_wr_valid    = fifo_valid;
  assign cfg_wr_stage_id = fifo_rdata[DW+16 +: 8];
  assign cfg_wr_res_id   = fifo_rdata[DW+8 +: 8];
  assign cfg_wr_index    = fifo_rdata[DW +: 8];
  assign cfg_wr_data     = fifo_rdata[DW-1:0];
  assign cfg_err         = err_q;
  assign cfg_pkt_cnt     = pkt_cnt_q;
  assign cfg_drop_cnt    = drop_cnt_q;

endmodule
